pe_feeder: RTL and testbench

- Drives one processing element (PE) MAC through a dot product of length N.
- Fetches data/weight operands from two read-only SRAM ports.
- Issues operands to the PE with per-operand valid strobes and feeds the running partial sum back on the psum input.
- Collects the PE's returned psum and reports the final result. Sits between the operand buffers and a PE instance, one feeder per PE.

---
 rtl/pe_feeder_pkg.sv | 15 +
 rtl/pe_feeder_addr_gen.sv | 28 ++
 rtl/pe_feeder.sv | 168 ++++++++++++++++
 tb/tb_pe_feeder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_feeder_pkg.sv
// Shared constants for the PE feeder: FSM state encoding and the PE pipeline depth.
package pe_feeder_pkg;

   localparam int MUL_LAT = 3;
   localparam int PE_LAT  = MUL_LAT + 1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_ISSUE = 3'd2,
      ST_WAIT  = 3'd3,
      ST_FIN   = 3'd4
   } state_t;

endpackage

// File: rtl/pe_feeder_addr_gen.sv
// Operand address counters for the data and weight SRAMs (base + element index, wrapping).
module pe_feeder_addr_gen #(
   parameter int ADDR_WIDTH = 10
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  step,
   input  logic [ADDR_WIDTH-1:0] data_base,
   input  logic [ADDR_WIDTH-1:0] weight_base,
   output logic [ADDR_WIDTH-1:0] data_addr,
   output logic [ADDR_WIDTH-1:0] weight_addr
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_addr   <= '0;
         weight_addr <= '0;
      end else if (load) begin
         data_addr   <= data_base;
         weight_addr <= weight_base;
      end else if (step) begin
         data_addr   <= data_addr + 1'b1;
         weight_addr <= weight_addr + 1'b1;
      end
   end

endmodule

// File: rtl/pe_feeder.sv
// Feeds one PE a length-N dot product from two operand SRAMs, one element in flight at a time.
// Defining PE_FEEDER_TIMEOUT_EN adds a watchdog on the PE return and the sticky o_err output.
module pe_feeder
   import pe_feeder_pkg::*;
#(
   parameter int BIT_WIDTH  = 8,
   parameter int ADDR_WIDTH = 10,
   parameter int LEN_WIDTH  = 10
`ifdef PE_FEEDER_TIMEOUT_EN
   ,parameter int TIMEOUT   = 16
`endif
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_start,
   input  logic [LEN_WIDTH-1:0]  i_len,
   input  logic [ADDR_WIDTH-1:0] i_data_base,
   input  logic [ADDR_WIDTH-1:0] i_weight_base,
   output logic [ADDR_WIDTH-1:0] o_data_addr,
   output logic                  o_data_ren,
   input  logic [BIT_WIDTH-1:0]  i_data_rdata,
   output logic [ADDR_WIDTH-1:0] o_weight_addr,
   output logic                  o_weight_ren,
   input  logic [BIT_WIDTH-1:0]  i_weight_rdata,
   output logic [BIT_WIDTH-1:0]  o_data,
   output logic                  o_data_val,
   output logic [BIT_WIDTH-1:0]  o_weight,
   output logic                  o_weight_val,
   output logic [BIT_WIDTH-1:0]  o_psum,
   output logic                  o_psum_val,
   input  logic [BIT_WIDTH-1:0]  i_psum,
   input  logic                  i_psum_val,
   output logic                  o_busy,
   output logic [BIT_WIDTH-1:0]  o_result,
   output logic                  o_done
`ifdef PE_FEEDER_TIMEOUT_EN
   ,output logic                 o_err
`endif
);

   state_t               state;
   logic [LEN_WIDTH-1:0] len;
   logic [LEN_WIDTH-1:0] count;
   logic [BIT_WIDTH-1:0] acc;
   logic                 ren;
   logic                 opnd_val;
   logic                 accept;
   logic                 step;
   logic                 abort;

   // o_done marks the first IDLE cycle after FIN; a start seen then is dropped.
   assign accept = (state == ST_IDLE) && i_start && !o_done;
   assign step   = (state == ST_WAIT) && i_psum_val && !abort;

`ifdef PE_FEEDER_TIMEOUT_EN
   localparam int WDOG_W = $clog2(TIMEOUT + 1);
   logic [WDOG_W-1:0] wdog;
   assign abort = (state == ST_WAIT) && (wdog == WDOG_W'(TIMEOUT - 1));
`else
   assign abort = 1'b0;
`endif

   pe_feeder_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
      .clk         (clk),
      .rst         (rst),
      .load        (accept),
      .step        (step),
      .data_base   (i_data_base),
      .weight_base (i_weight_base),
      .data_addr   (o_data_addr),
      .weight_addr (o_weight_addr)
   );

   // SRAM data is only valid in ISSUE, so the operands pass straight through, gated by the strobe.
   assign o_data_ren   = ren;
   assign o_weight_ren = ren;
   assign o_data_val   = opnd_val;
   assign o_weight_val = opnd_val;
   assign o_data       = opnd_val ? i_data_rdata : '0;
   assign o_weight     = opnd_val ? i_weight_rdata : '0;
   assign o_psum       = acc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         len        <= '0;
         count      <= '0;
         acc        <= '0;
         ren        <= 1'b0;
         opnd_val   <= 1'b0;
         o_psum_val <= 1'b0;
         o_busy     <= 1'b0;
         o_result   <= '0;
         o_done     <= 1'b0;
`ifdef PE_FEEDER_TIMEOUT_EN
         wdog       <= '0;
         o_err      <= 1'b0;
`endif
      end else begin
         o_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  len    <= i_len;
                  count  <= '0;
                  acc    <= '0;
                  o_busy <= 1'b1;
`ifdef PE_FEEDER_TIMEOUT_EN
                  o_err  <= 1'b0;
`endif
                  if (i_len == '0) begin
                     state <= ST_FIN;
                  end else begin
                     state <= ST_READ;
                     ren   <= 1'b1;
                  end
               end
            end
            ST_READ: begin
               ren      <= 1'b0;
               opnd_val <= 1'b1;
               state    <= ST_ISSUE;
            end
            ST_ISSUE: begin
               opnd_val   <= 1'b0;
               o_psum_val <= 1'b1;
               state      <= ST_WAIT;
`ifdef PE_FEEDER_TIMEOUT_EN
               wdog       <= '0;
`endif
            end
            ST_WAIT: begin
               if (abort) begin
                  o_psum_val <= 1'b0;
                  o_busy     <= 1'b0;
                  state      <= ST_IDLE;
`ifdef PE_FEEDER_TIMEOUT_EN
                  o_err      <= 1'b1;
`endif
               end else if (i_psum_val) begin
                  acc        <= i_psum;
                  count      <= count + 1'b1;
                  o_psum_val <= 1'b0;
                  if (count + 1'b1 == len) begin
                     state <= ST_FIN;
                  end else begin
                     state <= ST_READ;
                     ren   <= 1'b1;
                  end
               end
`ifdef PE_FEEDER_TIMEOUT_EN
               else begin
                  wdog <= wdog + 1'b1;
               end
`endif
            end
            ST_FIN: begin
               o_result <= acc;
               o_done   <= 1'b1;
               o_busy   <= 1'b0;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pe_feeder.sv
// Randomized bench for pe_feeder with SRAM and PE models; expected sums come from plain arithmetic.
// Define PE_FEEDER_TIMEOUT_EN to also exercise the watchdog and o_err.
module tb_pe_feeder;
   import pe_feeder_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       i_start = 1'b0;
   logic [9:0] i_len = '0;
   logic [9:0] i_data_base = '0;
   logic [9:0] i_weight_base = '0;
   logic [9:0] o_data_addr, o_weight_addr;
   logic       o_data_ren, o_weight_ren;
   logic [7:0] d_rdata = '0;
   logic [7:0] w_rdata = '0;
   logic [7:0] o_data, o_weight, o_psum, o_result;
   logic       o_data_val, o_weight_val, o_psum_val, o_busy, o_done;
   logic [7:0] pe_psum;
   logic       pe_psum_val;
`ifdef PE_FEEDER_TIMEOUT_EN
   logic       o_err;
`endif

   logic [7:0] dmem [1024];
   logic [7:0] wmem [1024];
   int  n_checks = 0;
   int  n_errors = 0;
   int  cyc = 0;
   int  dv_cnt = 0;
   int  ren_cnt = 0;
   int  done_cnt = 0;
   int  dv_cyc_q[$];
   int  daddr_q[$];
   int  waddr_q[$];

   pe_feeder dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_len(i_len),
      .i_data_base(i_data_base), .i_weight_base(i_weight_base),
      .o_data_addr(o_data_addr), .o_data_ren(o_data_ren), .i_data_rdata(d_rdata),
      .o_weight_addr(o_weight_addr), .o_weight_ren(o_weight_ren), .i_weight_rdata(w_rdata),
      .o_data(o_data), .o_data_val(o_data_val), .o_weight(o_weight), .o_weight_val(o_weight_val),
      .o_psum(o_psum), .o_psum_val(o_psum_val), .i_psum(pe_psum), .i_psum_val(pe_psum_val),
      .o_busy(o_busy), .o_result(o_result), .o_done(o_done)
`ifdef PE_FEEDER_TIMEOUT_EN
      ,.o_err(o_err)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Synchronous-read SRAMs: data appears the cycle after ren.
   always @(posedge clk) begin
      if (o_data_ren)   d_rdata <= dmem[o_data_addr];
      if (o_weight_ren) w_rdata <= wmem[o_weight_addr];
   end

   // PE: product captured at issue, psum returned PE_LAT cycles later using the live i_psum.
   logic       pe_pend = 1'b0;
   int         pe_cnt = 0;
   logic [7:0] pe_prod = '0;
   bit         pe_mute = 1'b0;
   always @(posedge clk) begin
      if (o_data_val && o_weight_val) begin
         pe_pend <= 1'b1;
         pe_cnt  <= PE_LAT - 1;
         pe_prod <= o_data * o_weight;
      end else if (pe_pend) begin
         if (pe_cnt == 0) pe_pend <= 1'b0;
         else             pe_cnt  <= pe_cnt - 1;
      end
   end
   assign pe_psum_val = pe_pend && (pe_cnt == 0) && !pe_mute;
   assign pe_psum     = pe_prod + o_psum;

   always @(negedge clk) begin
      if (rst) begin
         if (o_data_val) begin
            dv_cnt++;
            dv_cyc_q.push_back(cyc);
         end
         if (o_data_ren) begin
            ren_cnt++;
            daddr_q.push_back(int'(o_data_addr));
         end
         if (o_weight_ren) waddr_q.push_back(int'(o_weight_addr));
         if (o_done) done_cnt++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
      n_checks++;
      if (got !== expv) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, expv);
      end
   endtask

   // poke: 0 plain, 1 = start with other fields while busy, 2 = start during the o_done cycle.
   task automatic run_job(input int n, input int db, input int wb, input int poke, input string tag);
      logic [7:0] exp_res;
      int got_k, dv0, dn0, bad;
      exp_res = '0;
      for (int e = 0; e < n; e++)
         exp_res = exp_res + dmem[(db + e) % 1024] * wmem[(wb + e) % 1024];
      dv0 = dv_cnt;
      dn0 = done_cnt;
      dv_cyc_q.delete();
      daddr_q.delete();
      waddr_q.delete();
      @(negedge clk);
      i_start = 1'b1;
      i_len = 10'(n);
      i_data_base = 10'(db);
      i_weight_base = 10'(wb);
      got_k = -1;
      for (int k = 1; k <= 6 * n + 40; k++) begin
         @(negedge clk);
         if (k == 1) i_start = 1'b0;
         if (poke == 1 && k == 3) begin
            i_start = 1'b1;
            i_len = 10'(n + 3);
            i_data_base = 10'(db + 7);
            i_weight_base = 10'(wb + 9);
         end
         if (poke == 1 && k == 4) i_start = 1'b0;
         if (o_done) begin
            got_k = k;
            break;
         end
      end
      check({tag, " latency"}, got_k, 6 * n + 2);
      check({tag, " result"}, o_result, exp_res);
      if (poke == 2) begin
         i_start = 1'b1;
         i_len = 10'd1;
         @(negedge clk);
         i_start = 1'b0;
         check({tag, " start_on_done busy"}, o_busy, 1'b0);
         check({tag, " start_on_done ren"}, o_data_ren, 1'b0);
      end
      repeat (3) @(negedge clk);
      check({tag, " done_pulses"}, done_cnt - dn0, 1);
      check({tag, " issues"}, dv_cnt - dv0, n);
      check({tag, " reads"}, daddr_q.size() + waddr_q.size(), 2 * n);
      bad = 0;
      for (int e = 0; e < daddr_q.size() && e < waddr_q.size(); e++)
         if (daddr_q[e] != (db + e) % 1024 || waddr_q[e] != (wb + e) % 1024) bad++;
      check({tag, " bad_addrs"}, bad, 0);
      bad = 0;
      for (int e = 1; e < dv_cyc_q.size(); e++)
         if (dv_cyc_q[e] - dv_cyc_q[e - 1] != 2 + PE_LAT) bad++;
      check({tag, " bad_gaps"}, bad, 0);
   endtask

   task automatic reset_mid_job();
      int dv0, dn0, r0;
      bit hit;
      dv0 = dv_cnt;
      @(negedge clk);
      i_start = 1'b1;
      i_len = 10'd4;
      i_data_base = 10'($urandom_range(0, 1023));
      i_weight_base = 10'($urandom_range(0, 1023));
      hit = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (k == 1) i_start = 1'b0;
         if (dv_cnt - dv0 == 2 && o_psum_val) begin
            hit = 1'b1;
            break;
         end
      end
      check("rst reached_wait2", hit, 1'b1);
      rst = 1'b0;
      #1;
      check("rst ctrl_outs", {o_busy, o_psum_val, o_data_ren, o_weight_ren, o_data_val, o_weight_val, o_done}, '0);
      check("rst data_outs", {o_result, o_psum, o_data, o_weight}, '0);
      check("rst addrs", {o_data_addr, o_weight_addr}, '0);
      @(negedge clk);
      rst = 1'b1;
      dn0 = done_cnt;
      r0 = ren_cnt;
      repeat (10) @(negedge clk);
      check("rst no_done", done_cnt - dn0, 0);
      check("rst late_psum_ignored", ren_cnt - r0, 0);
      check("rst idle", o_busy, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         dmem[i] = 8'($urandom_range(0, 255));
         wmem[i] = 8'($urandom_range(0, 255));
      end
      repeat (3) @(negedge clk);
      check("reset ctrl", {o_busy, o_psum_val, o_data_ren, o_weight_ren, o_data_val, o_done}, '0);
      check("reset data", {o_result, o_psum}, '0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      dmem[16] = 8'd2; dmem[17] = 8'd3; dmem[18] = 8'd4;
      wmem[32] = 8'd5; wmem[33] = 8'd6; wmem[34] = 8'd7;
      run_job(3, 16, 32, 0, "n3");
      check("n3 value", o_result, 8'd56);
      run_job(0, 5, 6, 0, "n0");
      dmem[100] = 8'd200; dmem[101] = 8'd100;
      wmem[200] = 8'd1;   wmem[201] = 8'd1;
      run_job(2, 100, 200, 0, "n2wrap");
      check("n2wrap value", o_result, 8'd44);
      run_job(4, 300, 400, 1, "busy_start");
      run_job(1, 500, 600, 2, "done_start");
      reset_mid_job();
      run_job(3, 16, 32, 0, "after_rst");
      run_job(5, 1022, 1023, 0, "addr_wrap");
      for (int j = 0; j < 6; j++)
         run_job($urandom_range(1, 12), $urandom_range(0, 1023), $urandom_range(0, 1023), 0, "rand");

`ifdef PE_FEEDER_TIMEOUT_EN
      begin
         int got_k, dn0;
         pe_mute = 1'b1;
         dn0 = done_cnt;
         @(negedge clk);
         i_start = 1'b1;
         i_len = 10'd2;
         got_k = -1;
         for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) i_start = 1'b0;
            if (o_err) begin
               got_k = k;
               break;
            end
         end
         check("timeout latency", got_k, 19);
         check("timeout idle", o_busy, 1'b0);
         repeat (4) @(negedge clk);
         check("timeout no_done", done_cnt - dn0, 0);
         check("timeout err_sticky", o_err, 1'b1);
         pe_mute = 1'b0;
         run_job(2, 16, 32, 0, "post_timeout");
         check("timeout err_cleared", o_err, 1'b0);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, checks %0d", n_checks);
      $fatal(1);
   end

endmodule
